sram_readout: RTL and testbench
===============================

Name: sram_readout

Overview:
- Reader side of the capture buffer. The synchronization block fills external SRAM circularly until the window counter stops writes; this block then replays the stored window to the MCU, byte by byte.
- It computes the oldest-sample address from the trigger address and pre-trigger length, then drives the SRAM address and output-enable.
- It presents each byte with a valid strobe on an MCU request handshake.
- It sits between the SRAM data bus and the MCU parallel interface, and is active only while SRAM writes are stopped.

Parameters:
- ADDR_W, 19, SRAM address width; buffer depth is 2^ADDR_W, circular.
- RD_LAT, 2, CLK cycles from address/OE valid to SRAM data sampled; legal 1..7.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- START_READ  input  1  single-cycle pulse; latches TRIG_ADDR, PRE_LEN, READ_LEN and starts a readout.
- TRIG_ADDR  input  ADDR_W  SRAM write address captured at the trigger event.
- PRE_LEN  input  ADDR_W  number of samples preceding the trigger to return.
- READ_LEN  input  ADDR_W  total samples to return; 0 = none.
- MCU_RD  input  1  request strobe; rising edge (detected internally, registered) requests the next byte.
- SRAM_DATA_IN  input  8  SRAM read data.
- SRAM_ADDR  output  ADDR_W  SRAM read address.
- SRAM_OE  output  1  SRAM output enable, active-low.
- DATA_OUT  output  8  byte to MCU, held stable until next fetch.
- DATA_VALID  output  1  high from byte capture until next MCU_RD edge.
- BUSY  output  1  high from START_READ until DONE.
- DONE  output  1  high after last byte delivered; cleared by next START_READ.
- RD_OVERRUN  output  1  sticky; MCU_RD edge arrived while a fetch was in flight.

Behaviour:
- Reset values:
  - SRAM_ADDR=0, SRAM_OE=1, DATA_OUT=0, DATA_VALID=0, BUSY=0, DONE=0, RD_OVERRUN=0.
  - FSM in IDLE, all counters 0.
- FSM states IDLE, READY, FETCH, PRESENT, FINISH.
- IDLE:
  - START_READ -> latch inputs.
  - Set SRAM_ADDR = (TRIG_ADDR - PRE_LEN) mod 2^ADDR_W, remaining = READ_LEN, BUSY=1, DONE=0, RD_OVERRUN=0.
  - Go to READY, or to FINISH if READ_LEN=0.
- READY: MCU_RD rising edge -> SRAM_OE=0, latency counter=0, DATA_VALID=0, go to FETCH.
- FETCH:
  - Counter increments each cycle.
  - When counter = RD_LAT-1: DATA_OUT <= SRAM_DATA_IN, DATA_VALID=1, SRAM_OE=1, SRAM_ADDR increments (wraps 2^ADDR_W-1 -> 0), remaining decrements, go to PRESENT.
- Latency: MCU_RD edge registered in cycle N -> OE low in cycle N+1 -> DATA_VALID high in cycle N+1+RD_LAT.
- PRESENT: remaining=0 -> FINISH; else go to READY immediately. DATA_VALID stays high until the next MCU_RD edge.
- FINISH: BUSY=0, DONE=1, return to IDLE; DONE and DATA_OUT held.
- MCU_RD edge in FETCH: ignored, RD_OVERRUN set.
- MCU_RD edge in IDLE: ignored, RD_OVERRUN unchanged.
- START_READ outside IDLE: ignored. Restart requires RST or completion.
- PRE_LEN > READ_LEN: legal, window is simply all pre-trigger samples.
- READ_LEN > depth: addresses wrap and repeat; no error flag.
- RST mid-readout: all outputs to reset values immediately (asynchronous); SRAM_OE deasserts without waiting for a clock edge.
- Address arithmetic is unsigned ADDR_W-bit, modulo 2^ADDR_W; no carry out.

Optional Feature:
- Macro SRAM_READOUT_CKSUM_EN.
- Defined:
  - Extra output CKSUM[7:0] (reset 0), cleared on accepted START_READ.
  - Updated CKSUM <= CKSUM XOR SRAM_DATA_IN in the same cycle DATA_OUT captures.
  - Valid as the final checksum when DONE=1.
- Undefined: port absent, no XOR logic; all other behaviour identical.

Decomposition:
- Shared package: FSM state encoding (IDLE..FINISH), default ADDR_W and RD_LAT constants, SRAM_OE active-level constant.
- One sub-module, readout_addr_ctr:
  - Loads the start address (subtract with wrap).
  - Increments on a step pulse.
  - Holds the remaining-count down-counter with zero flag.

Test Plan:
- TRIG_ADDR=0x00100, PRE_LEN=0x10, READ_LEN=4, SRAM pattern data=addr[7:0]; 4 MCU_RD pulses -> bytes F0,F1,F2,F3 from addresses 0x000F0..0x000F3, then DONE=1, BUSY=0.
- TRIG_ADDR=0x00002, PRE_LEN=4, READ_LEN=6 -> addresses 0x7FFFE, 0x7FFFF, 0x00000..0x00003 (wrap checked).
- RD_LAT=2; MCU_RD edge -> SRAM_OE low exactly 1 cycle after the registered edge; DATA_VALID high exactly 2 cycles after that.
- Second MCU_RD edge 1 cycle after the first, while in FETCH -> RD_OVERRUN=1, only one address step, byte count unchanged.
- Assert RST during FETCH of byte 3 of 8 -> SRAM_OE=1 and BUSY=0 asynchronously; a new START_READ afterwards restarts from the recomputed start address.
- READ_LEN=0 -> DONE within 2 cycles, SRAM_OE never low. With SRAM_READOUT_CKSUM_EN, bytes 0x12, 0x34, 0x0F -> CKSUM=0x29.

Source files
------------

// File: rtl/sram_readout_pkg.sv
// Shared definitions for the SRAM capture-buffer readout: FSM encoding,
// default geometry/latency and the SRAM output-enable levels.
package sram_readout_pkg;

  localparam int DEF_ADDR_W = 19;
  localparam int DEF_RD_LAT = 2;
  localparam int LAT_W      = 3;  // wide enough for RD_LAT up to 7

  localparam logic OE_ACTIVE   = 1'b0;
  localparam logic OE_INACTIVE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READY,
    ST_FETCH,
    ST_PRESENT,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/readout_addr_ctr.sv
// Readout address generator: loads the oldest-sample address (trigger minus
// pre-trigger length, modulo depth), steps it per byte, and counts bytes left.
module readout_addr_ctr
  import sram_readout_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] trig_addr,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [ADDR_W-1:0] read_len,
  output logic [ADDR_W-1:0] addr,
  output logic              zero
);

  logic [ADDR_W-1:0] remaining;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= trig_addr - pre_len;  // unsigned wrap is the circular buffer
      remaining <= read_len;
    end else if (step) begin
      addr      <= addr + ADDR_W'(1);
      remaining <= remaining - ADDR_W'(1);
    end
  end

  assign zero = (remaining == '0);

endmodule

// File: rtl/sram_readout.sv
// Replays the captured SRAM window to the MCU one byte per MCU_RD edge.
// Optional running XOR checksum output CKSUM when SRAM_READOUT_CKSUM_EN is defined.
module sram_readout
  import sram_readout_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START_READ,
  input  logic [ADDR_W-1:0] TRIG_ADDR,
  input  logic [ADDR_W-1:0] PRE_LEN,
  input  logic [ADDR_W-1:0] READ_LEN,
  input  logic              MCU_RD,
  input  logic [7:0]        SRAM_DATA_IN,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_OE,
  output logic [7:0]        DATA_OUT,
  output logic              DATA_VALID,
  output logic              BUSY,
  output logic              DONE,
  output logic              RD_OVERRUN
`ifdef SRAM_READOUT_CKSUM_EN
  ,
  output logic [7:0]        CKSUM
`endif
);

  state_t             state, state_nxt;
  logic               rd_d1, rd_d2, rd_edge;
  logic [LAT_W-1:0]   lat_cnt;
  logic               lat_done;
  logic               rem_zero;
  logic               do_load, do_issue, do_capture, do_overrun, do_finish;

  // Request edge comes from registered samples so the FSM never sees a glitch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_d1 <= 1'b0;
      rd_d2 <= 1'b0;
    end else begin
      rd_d1 <= MCU_RD;
      rd_d2 <= rd_d1;
    end
  end

  assign rd_edge  = rd_d1 & ~rd_d2;
  assign lat_done = (lat_cnt == LAT_W'(RD_LAT - 1));

  readout_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
    .clk       (CLK),
    .rst       (RST),
    .load      (do_load),
    .step      (do_capture),
    .trig_addr (TRIG_ADDR),
    .pre_len   (PRE_LEN),
    .read_len  (READ_LEN),
    .addr      (SRAM_ADDR),
    .zero      (rem_zero)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (START_READ) state_nxt = (READ_LEN == '0) ? ST_FINISH : ST_READY;
      ST_READY:   if (rd_edge)    state_nxt = ST_FETCH;
      ST_FETCH:   if (lat_done)   state_nxt = ST_PRESENT;
      ST_PRESENT: state_nxt = rem_zero ? ST_FINISH : ST_READY;
      ST_FINISH:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    do_load    = 1'b0;
    do_issue   = 1'b0;
    do_capture = 1'b0;
    do_overrun = 1'b0;
    do_finish  = 1'b0;
    case (state)
      ST_IDLE:   do_load = START_READ;
      ST_READY:  do_issue = rd_edge;
      ST_FETCH: begin
        do_capture = lat_done;
        do_overrun = rd_edge;
      end
      ST_FINISH: do_finish = 1'b1;
      default: ;
    endcase
  end

  // Output/datapath registers; asynchronous reset drops SRAM_OE immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SRAM_OE    <= OE_INACTIVE;
      DATA_OUT   <= 8'h00;
      DATA_VALID <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      RD_OVERRUN <= 1'b0;
      lat_cnt    <= '0;
    end else begin
      if (state == ST_FETCH) lat_cnt <= lat_cnt + LAT_W'(1);
      if (do_load) begin
        BUSY       <= 1'b1;
        DONE       <= 1'b0;
        RD_OVERRUN <= 1'b0;
        lat_cnt    <= '0;
      end
      if (do_issue) begin
        SRAM_OE    <= OE_ACTIVE;
        DATA_VALID <= 1'b0;
        lat_cnt    <= '0;
      end
      if (do_capture) begin
        DATA_OUT   <= SRAM_DATA_IN;
        DATA_VALID <= 1'b1;
        SRAM_OE    <= OE_INACTIVE;
      end
      if (do_overrun) RD_OVERRUN <= 1'b1;
      if (do_finish) begin
        BUSY <= 1'b0;
        DONE <= 1'b1;
      end
    end
  end

`ifdef SRAM_READOUT_CKSUM_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             CKSUM <= 8'h00;
    else if (do_load)    CKSUM <= 8'h00;
    else if (do_capture) CKSUM <= CKSUM ^ SRAM_DATA_IN;
  end
`endif

endmodule

// File: tb/tb_sram_readout.sv
// Randomized self-checking bench for sram_readout against a queue-based
// window model and a behavioural SRAM; honours SRAM_READOUT_CKSUM_EN.
module tb_sram_readout;

  localparam int ADDR_W = 19;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_read;
  logic [ADDR_W-1:0] trig_addr, pre_len, read_len;
  logic              mcu_rd;
  logic [7:0]        sram_data = 8'h00;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_oe;
  logic [7:0]        data_out;
  logic              data_valid, busy, done, rd_overrun;
`ifdef SRAM_READOUT_CKSUM_EN
  logic [7:0]        cksum;
`endif

  sram_readout #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .CLK          (clk),
    .RST          (rst),
    .START_READ   (start_read),
    .TRIG_ADDR    (trig_addr),
    .PRE_LEN      (pre_len),
    .READ_LEN     (read_len),
    .MCU_RD       (mcu_rd),
    .SRAM_DATA_IN (sram_data),
    .SRAM_ADDR    (sram_addr),
    .SRAM_OE      (sram_oe),
    .DATA_OUT     (data_out),
    .DATA_VALID   (data_valid),
    .BUSY         (busy),
    .DONE         (done),
    .RD_OVERRUN   (rd_overrun)
`ifdef SRAM_READOUT_CKSUM_EN
    ,
    .CKSUM        (cksum)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         pat_mode = 0;
  logic [7:0] pat_seed = 8'h00;
  logic [7:0] ovr [int];
  int         exp_q[$];
  logic [7:0] exp_ck;

  // SRAM contents: explicit overrides, else a pattern of the address.
  function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
    if (ovr.exists(int'(a))) return ovr[int'(a)];
    if (pat_mode == 0) return a[7:0];
    return a[7:0] ^ a[15:8] ^ pat_seed;
  endfunction

  // SRAM with output enable; data settles well before the capture edge.
  always @(negedge clk) sram_data = sram_oe ? 8'hEE : mem_byte(sram_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_addr"}, sram_addr, 0);
    check({tag, "_oe"}, sram_oe, 1);
    check({tag, "_dout"}, data_out, 0);
    check({tag, "_dv"}, data_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ovr"}, rd_overrun, 0);
`ifdef SRAM_READOUT_CKSUM_EN
    check({tag, "_cksum"}, cksum, 0);
`endif
  endtask

  task automatic do_start(input int trig, input int pre, input int len);
    exp_q.delete();
    exp_ck = 8'h00;
    for (int i = 0; i < len; i++) exp_q.push_back((trig - pre + i) & (DEPTH - 1));
    @(negedge clk);
    trig_addr  = ADDR_W'(trig);
    pre_len    = ADDR_W'(pre);
    read_len   = ADDR_W'(len);
    start_read = 1'b1;
    @(negedge clk);
    start_read = 1'b0;
    check("busy_start", busy, 1);
    check("done_clr", done, 0);
    check("ovr_clr", rd_overrun, 0);
    if (len > 0) check("start_addr", sram_addr, exp_q[0]);
`ifdef SRAM_READOUT_CKSUM_EN
    check("cksum_clr", cksum, 0);
`endif
  endtask

  // One MCU request; dbl adds a second edge while the fetch is in flight.
  task automatic read_byte(input bit dbl, input bit chk_lat);
    int               t_oe = -1;
    int               t_dv = -1;
    int               exp_a;
    logic [ADDR_W-1:0] a_seen = '0;
    logic             dv_at_oe = 1'b0;
    logic [7:0]       exp_d;
    check("not_done", done, 0);
    exp_a = exp_q.pop_front();
    exp_d = mem_byte(ADDR_W'(exp_a));
    exp_ck ^= exp_d;
    mcu_rd = 1'b1;
    for (int i = 1; i <= 20 && t_dv < 0; i++) begin
      @(negedge clk);
      if (i == 1) mcu_rd = 1'b0;
      if (dbl && i == 2) mcu_rd = 1'b1;
      if (dbl && i == 3) mcu_rd = 1'b0;
      if (t_oe >= 0 && i > t_oe && data_valid) t_dv = i;
      if (t_oe < 0 && !sram_oe) begin
        t_oe = i;
        a_seen = sram_addr;
        dv_at_oe = data_valid;
      end
    end
    mcu_rd = 1'b0;
    if (t_dv < 0) begin
      check("dv_timeout", 0, 1);
      return;
    end
    check("rd_addr", a_seen, exp_a);
    check("rd_data", data_out, exp_d);
    check("oe_release", sram_oe, 1);
    if (chk_lat) begin
      check("oe_lat", t_oe, 2);
      check("dv_lat", t_dv - t_oe, RD_LAT);
      check("dv_clear", dv_at_oe, 0);
    end
  endtask

  task automatic wait_done(input bit exp_ovr);
    int t = -1;
    for (int i = 1; i <= 6 && t < 0; i++) begin
      @(negedge clk);
      if (done) t = i;
    end
    check("done_seen", t > 0, 1);
    check("busy_end", busy, 0);
    check("ovr_end", rd_overrun, exp_ovr);
`ifdef SRAM_READOUT_CKSUM_EN
    check("cksum_end", cksum, exp_ck);
`endif
  endtask

  task automatic read_all(input int n, input bit rnd_gap);
    for (int i = 0; i < n; i++) begin
      read_byte(1'b0, 1'b1);
      if (rnd_gap) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_read = 1'b0; mcu_rd = 1'b0;
    trig_addr = '0; pre_len = '0; read_len = '0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("post_rst");

    // Basic window, data = addr[7:0]
    do_start(32'h00100, 32'h10, 4);
    read_all(4, 1'b0);
    wait_done(1'b0);

    // Start address wraps below zero
    do_start(32'h00002, 4, 6);
    read_all(6, 1'b0);
    wait_done(1'b0);

    // Overrun: second edge while fetching, single address step
    do_start(32'h01234, 3, 8);
    read_byte(1'b0, 1'b1);
    read_byte(1'b1, 1'b1);
    check("ovr_set", rd_overrun, 1);
    check("ovr_one_step", sram_addr, exp_q[0]);
    read_all(6, 1'b0);
    wait_done(1'b1);
    // Request edge while idle is ignored
    mcu_rd = 1'b1;
    @(negedge clk); mcu_rd = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_rd_ovr", rd_overrun, 1);
    check("idle_rd_done", done, 1);
    check("idle_rd_oe", sram_oe, 1);

    // Asynchronous reset during fetch of byte 3 of 8, then restart
    do_start(32'h00050, 32'h20, 8);
    read_byte(1'b0, 1'b1);
    read_byte(1'b0, 1'b1);
    mcu_rd = 1'b1;
    @(negedge clk); mcu_rd = 1'b0;
    @(negedge clk);
    check("fetch3_oe", sram_oe, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_oe", sram_oe, 1);
    check("arst_busy", busy, 0);
    check("arst_dv", data_valid, 0);
    check("arst_addr", sram_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    do_start(32'h00050, 32'h20, 8);
    read_all(8, 1'b0);
    wait_done(1'b0);

    // Zero-length readout
    begin
      int  t_done = -1;
      bit  oe_low = 1'b0;
      do_start(32'h00077, 5, 0);
      for (int i = 1; i <= 5; i++) begin
        @(negedge clk);
        if (!sram_oe) oe_low = 1'b1;
        if (done && t_done < 0) t_done = i;
      end
      check("len0_done_lat", (t_done > 0) && (t_done <= 2), 1);
      check("len0_oe_idle", oe_low, 0);
      check("len0_busy", busy, 0);
    end

    // Known bytes for the checksum
    ovr[32'h40000] = 8'h12;
    ovr[32'h40001] = 8'h34;
    ovr[32'h40002] = 8'h0F;
    do_start(32'h40000, 0, 3);
    read_all(3, 1'b0);
    wait_done(1'b0);
`ifdef SRAM_READOUT_CKSUM_EN
    check("cksum_29", cksum, 8'h29);
`endif
    ovr.delete();

    // Randomized windows, including PRE_LEN > READ_LEN and large wraps
    pat_mode = 1;
    for (int r = 0; r < 8; r++) begin
      int trig = $urandom_range(0, DEPTH - 1);
      int pre  = (r % 3 == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 8);
      int len  = $urandom_range(1, 6);
      pat_seed = 8'($urandom);
      do_start(trig, pre, len);
      if (r == 1 && len > 1) begin
        read_byte(1'b0, 1'b1);
        @(negedge clk);
        trig_addr  = ADDR_W'($urandom);
        pre_len    = ADDR_W'($urandom);
        start_read = 1'b1;
        @(negedge clk);
        start_read = 1'b0;
        read_all(len - 1, 1'b1);
      end else begin
        read_all(len, 1'b1);
      end
      wait_done(1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
